// File: rtl/rx_frame_buf_if.sv
// Bundles the receiver-side write strobes, consumer read port and status outputs of rx_frame_buf.
// master drives payload/consumer inputs; slave is the frame buffer itself.
interface rx_frame_buf_if #(
  parameter int AW = 14
);
  logic [7:0]    din;
  logic [AW-1:0] wr_addr;
  logic          wr_en;
  logic [7:0]    div_in;
  logic          frm_end;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          frm_rdy;
  logic [AW-1:0] frm_len;
  logic [7:0]    frm_div;
  logic          frm_ack;
  logic [15:0]   drop_cnt;
  logic [15:0]   err_cnt;

  modport master (
    output din, wr_addr, wr_en, div_in, frm_end, rd_addr, frm_ack,
    input  rd_data, frm_rdy, frm_len, frm_div, drop_cnt, err_cnt
  );

  modport slave (
    input  din, wr_addr, wr_en, div_in, frm_end, rd_addr, frm_ack,
    output rd_data, frm_rdy, frm_len, frm_div, drop_cnt, err_cnt
  );
endinterface

// File: rtl/rx_frame_buf.sv
// Two-bank ping-pong frame buffer: the writer fills one bank while the consumer reads the other,
// a consumer ack frees the presented bank, and frames with no free bank are dropped and counted.
module rx_frame_buf #(
  parameter int DEPTH   = 4096,
  parameter int AW      = 14,
  parameter int MIN_LEN = 1
) (
  input  logic          rxclk,
  input  logic          rst,
  rx_frame_buf_if.slave bus
);
  localparam int LW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, DISCARD = 2'd2} state_t;

  state_t        state_q, state_d;
  logic          wbank_q, wbank_d;
  logic          rbank_q, rbank_d;
  logic [1:0]    full_q, full_d;
  logic [AW-1:0] len_q [2];
  logic [AW-1:0] len_d [2];
  logic [7:0]    div_q [2];
  logic [7:0]    div_d [2];
  logic [AW-1:0] len_acc_q, len_acc_d;
  logic          trunc_q, trunc_d;
  logic          rdy_q, rdy_d;
  logic [15:0]   drop_q, drop_d;
  logic [15:0]   err_q, err_d;
  logic [7:0]    rd_data_q;

  logic [7:0]    mem [2*DEPTH];
  logic          mem_we;
  logic [LW:0]   mem_waddr;
  logic [LW-1:0] wr_idx, rd_idx;

  logic          start, skip, filling, in_range;
  logic [AW-1:0] byte_len, cur_len;
  logic          cur_trunc;

  assign wr_idx = LW'(bus.wr_addr);
  assign rd_idx = LW'(bus.rd_addr);

  always_comb begin
    state_d   = state_q;
    wbank_d   = wbank_q;
    rbank_d   = rbank_q;
    full_d    = full_q;
    len_d     = len_q;
    div_d     = div_q;
    len_acc_d = len_acc_q;
    trunc_d   = trunc_q;
    drop_d    = drop_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_waddr = {wbank_q, wr_idx};

    in_range = bus.wr_addr < AW'(DEPTH);
    byte_len = bus.wr_addr + AW'(1);
    start    = (state_q == IDLE) && bus.wr_en && !full_q[wbank_q];
    skip     = (state_q == IDLE) && bus.wr_en && full_q[wbank_q];
    filling  = start || (state_q == FILL);

    // A frame's first byte starts from an empty length/truncation record.
    cur_len   = (state_q == FILL) ? len_acc_q : '0;
    cur_trunc = (state_q == FILL) ? trunc_q : 1'b0;
    if (filling && bus.wr_en) begin
      if (in_range) begin
        mem_we = !rst;
        if (byte_len > cur_len) cur_len = byte_len;
      end else begin
        cur_trunc = 1'b1;
      end
    end

    if (filling) begin
      state_d   = FILL;
      len_acc_d = cur_len;
      trunc_d   = cur_trunc;
      if (bus.frm_end) begin
        state_d = IDLE;
        if (!cur_trunc && (cur_len >= AW'(MIN_LEN))) begin
          full_d[wbank_q] = 1'b1;
          len_d[wbank_q]  = cur_len;
          div_d[wbank_q]  = bus.div_in;
          wbank_d         = ~wbank_q;
        end else if (err_q != 16'hFFFF) begin
          err_d = err_q + 16'd1;
        end
      end
    end

    if (skip || (state_q == DISCARD)) begin
      state_d = DISCARD;
      if (bus.frm_end) begin
        state_d = IDLE;
        if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
      end
    end

    // The writer only ever commits into an empty bank, so a same-cycle ack never collides with it.
    rdy_d = full_q[rbank_q];
    if (bus.frm_ack && rdy_q) begin
      full_d[rbank_q] = 1'b0;
      rbank_d         = ~rbank_q;
      rdy_d           = 1'b0;
    end
  end

  always_ff @(posedge rxclk) begin
    if (rst) begin
      state_q   <= IDLE;
      wbank_q   <= 1'b0;
      rbank_q   <= 1'b0;
      full_q    <= '0;
      len_acc_q <= '0;
      trunc_q   <= 1'b0;
      rdy_q     <= 1'b0;
      drop_q    <= '0;
      err_q     <= '0;
      for (int i = 0; i < 2; i++) begin
        len_q[i] <= '0;
        div_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      wbank_q   <= wbank_d;
      rbank_q   <= rbank_d;
      full_q    <= full_d;
      len_acc_q <= len_acc_d;
      trunc_q   <= trunc_d;
      rdy_q     <= rdy_d;
      drop_q    <= drop_d;
      err_q     <= err_d;
      len_q     <= len_d;
      div_q     <= div_d;
    end
  end

  always_ff @(posedge rxclk) begin
    if (mem_we) mem[mem_waddr] <= bus.din;
  end

  always_ff @(posedge rxclk) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= mem[{rbank_q, rd_idx}];
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.frm_rdy  = rdy_q;
  assign bus.frm_len  = len_q[rbank_q];
  assign bus.frm_div  = div_q[rbank_q];
  assign bus.drop_cnt = drop_q;
  assign bus.err_cnt  = err_q;
endmodule

// File: tb/tb_rx_frame_buf.sv
// Bench for rx_frame_buf: read data goes through an expected-value queue, status via direct checks;
// a second instance with MIN_LEN=8 shares the same stimulus for the short-frame case.
module tb_rx_frame_buf;
  localparam int DEPTH = 4096;
  localparam int AW    = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic [7:0]    din = '0;
  logic [7:0]    div_in = '0;
  logic [AW-1:0] wr_addr = '0;
  logic [AW-1:0] rd_addr = '0;
  logic          wr_en = 1'b0;
  logic          frm_end = 1'b0;
  logic          frm_ack = 1'b0;

  rx_frame_buf_if #(.AW(AW)) bus0 ();
  rx_frame_buf_if #(.AW(AW)) bus8 ();

  assign bus0.din = din;      assign bus8.din = din;
  assign bus0.wr_addr = wr_addr; assign bus8.wr_addr = wr_addr;
  assign bus0.wr_en = wr_en;  assign bus8.wr_en = wr_en;
  assign bus0.div_in = div_in; assign bus8.div_in = div_in;
  assign bus0.frm_end = frm_end; assign bus8.frm_end = frm_end;
  assign bus0.rd_addr = rd_addr; assign bus8.rd_addr = rd_addr;
  assign bus0.frm_ack = frm_ack; assign bus8.frm_ack = frm_ack;

  rx_frame_buf #(.DEPTH(DEPTH), .AW(AW), .MIN_LEN(1)) dut (.rxclk(clk), .rst(rst), .bus(bus0));
  rx_frame_buf #(.DEPTH(DEPTH), .AW(AW), .MIN_LEN(8)) dut8 (.rxclk(clk), .rst(rst), .bus(bus8));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  // Read scoreboard: expected bytes are queued as addresses are driven and popped one edge later.
  logic [7:0] exp_q[$];
  bit rd_req = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      if (rd_req) begin
        #1;
        if (exp_q.size() == 0) chk("rd_underflow", 32'd1, 32'd0);
        else chk("rd_data", {24'd0, bus0.rd_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic rd(input logic [AW-1:0] a, input logic [7:0] e);
    @(negedge clk);
    rd_addr = a;
    rd_req  = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic rd_done();
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic write_frame(input int n, input logic [7:0] x, input logic [7:0] dv,
                             input bit bad, input bit ack);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_addr = AW'(i); din = 8'(i) ^ x;
    end
    if (bad) begin
      @(negedge clk);
      wr_en = 1'b1; wr_addr = AW'(DEPTH); din = 8'hEE;
    end
    @(negedge clk);
    wr_en = 1'b0; frm_end = 1'b1; div_in = dv; frm_ack = ack;
    @(negedge clk);
    frm_end = 1'b0; frm_ack = 1'b0;
  endtask

  task automatic do_ack();
    @(negedge clk);
    frm_ack = 1'b1;
    @(negedge clk);
    frm_ack = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    exp;
  } rd_vec_t;

  rd_vec_t tbl[6];

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{addr: 14'd10, exp: 8'h50};
    tbl[1] = '{addr: 14'd0,  exp: 8'h5A};
    tbl[2] = '{addr: 14'd63, exp: 8'h65};
    tbl[3] = '{addr: 14'd1,  exp: 8'h5B};
    tbl[4] = '{addr: 14'd32, exp: 8'h7A};
    tbl[5] = '{addr: 14'd33, exp: 8'h7B};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_rdy", {31'd0, bus0.frm_rdy}, 32'd0);
    chk("rst_len", {18'd0, bus0.frm_len}, 32'd0);
    chk("rst_div", {24'd0, bus0.frm_div}, 32'd0);
    chk("rst_rd_data", {24'd0, bus0.rd_data}, 32'd0);
    chk("rst_drop", {16'd0, bus0.drop_cnt}, 32'd0);
    chk("rst_err", {16'd0, bus0.err_cnt}, 32'd0);
    rst = 1'b0;

    // 64-byte frame, readiness two cycles after frm_end, table-driven reads, ack
    write_frame(64, 8'h5A, 8'h03, 1'b0, 1'b0);
    chk("t1_rdy_lat1", {31'd0, bus0.frm_rdy}, 32'd0);
    @(negedge clk);
    chk("t1_rdy", {31'd0, bus0.frm_rdy}, 32'd1);
    chk("t1_len", {18'd0, bus0.frm_len}, 32'd64);
    chk("t1_div", {24'd0, bus0.frm_div}, 32'h03);
    for (int i = 0; i < 6; i++) rd(tbl[i].addr, tbl[i].exp);
    rd_done();
    do_ack();
    chk("t1_ack_rdy", {31'd0, bus0.frm_rdy}, 32'd0);
    @(negedge clk);
    chk("t1_ack_rdy2", {31'd0, bus0.frm_rdy}, 32'd0);

    // Two committed frames, third dropped, then ack reveals the second
    write_frame(16, 8'h11, 8'hA1, 1'b0, 1'b0);
    write_frame(32, 8'h22, 8'hB2, 1'b0, 1'b0);
    chk("t2_rdy_a", {31'd0, bus0.frm_rdy}, 32'd1);
    chk("t2_len_a", {18'd0, bus0.frm_len}, 32'd16);
    write_frame(8, 8'h33, 8'hC3, 1'b0, 1'b0);
    chk("t2_drop", {16'd0, bus0.drop_cnt}, 32'd1);
    chk("t2_len_a_kept", {18'd0, bus0.frm_len}, 32'd16);
    rd(14'd3, 8'h12);
    rd_done();
    do_ack();
    chk("t2_ack_rdy", {31'd0, bus0.frm_rdy}, 32'd0);
    @(negedge clk);
    chk("t2_rdy_b", {31'd0, bus0.frm_rdy}, 32'd1);
    chk("t2_len_b", {18'd0, bus0.frm_len}, 32'd32);
    chk("t2_div_b", {24'd0, bus0.frm_div}, 32'hB2);
    rd(14'd5, 8'h27);
    rd(14'd31, 8'h3D);
    rd_done();
    do_ack();

    // Truncated frame rejected, next frame commits into the same bank
    write_frame(4, 8'h44, 8'h0B, 1'b1, 1'b0);
    chk("t3_err", {16'd0, bus0.err_cnt}, 32'd1);
    @(negedge clk);
    chk("t3_rdy0", {31'd0, bus0.frm_rdy}, 32'd0);
    write_frame(12, 8'h44, 8'h0C, 1'b0, 1'b0);
    @(negedge clk);
    chk("t3_rdy", {31'd0, bus0.frm_rdy}, 32'd1);
    chk("t3_len", {18'd0, bus0.frm_len}, 32'd12);
    chk("t3_div", {24'd0, bus0.frm_div}, 32'h0C);
    rd(14'd2, 8'h46);
    rd(14'd11, 8'h4F);
    rd_done();
    do_ack();

    // Ack coincides with the second frame's frm_end
    write_frame(20, 8'h66, 8'h51, 1'b0, 1'b0);
    @(negedge clk);
    chk("t5_rdy1", {31'd0, bus0.frm_rdy}, 32'd1);
    write_frame(9, 8'h77, 8'h92, 1'b0, 1'b1);
    chk("t5_gap", {31'd0, bus0.frm_rdy}, 32'd0);
    @(negedge clk);
    chk("t5_rdy2", {31'd0, bus0.frm_rdy}, 32'd1);
    chk("t5_len", {18'd0, bus0.frm_len}, 32'd9);
    chk("t5_div", {24'd0, bus0.frm_div}, 32'h92);
    rd(14'd8, 8'h7F);
    rd_done();
    do_ack();

    // Reset in the middle of a frame, then a fresh short frame
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_addr = AW'(i); din = 8'(i);
    end
    @(negedge clk);
    wr_en = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    write_frame(5, 8'h88, 8'h06, 1'b0, 1'b0);
    @(negedge clk);
    chk("t6_rdy", {31'd0, bus0.frm_rdy}, 32'd1);
    chk("t6_len", {18'd0, bus0.frm_len}, 32'd5);
    chk("t6_div", {24'd0, bus0.frm_div}, 32'h06);
    chk("t6_err", {16'd0, bus0.err_cnt}, 32'd0);
    chk("t6_drop", {16'd0, bus0.drop_cnt}, 32'd0);
    rd(14'd4, 8'h8C);
    rd_done();

    // Minimum-length rejection on the MIN_LEN=8 instance
    do_reset();
    write_frame(4, 8'h99, 8'h04, 1'b0, 1'b0);
    chk("t4_err", {16'd0, bus8.err_cnt}, 32'd1);
    @(negedge clk);
    chk("t4_rdy0", {31'd0, bus8.frm_rdy}, 32'd0);
    write_frame(8, 8'h99, 8'h08, 1'b0, 1'b0);
    @(negedge clk);
    chk("t4_rdy", {31'd0, bus8.frm_rdy}, 32'd1);
    chk("t4_len", {18'd0, bus8.frm_len}, 32'd8);
    chk("t4_err_kept", {16'd0, bus8.err_cnt}, 32'd1);

    repeat (2) @(negedge clk);
    chk("sb_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rx_frame_buf.md
Name: rx_frame_buf

Overview:
- Ping-pong frame buffer directly downstream of the RGMII byte receiver.
- Accepts addressed payload bytes plus the per-frame div header byte, all in the rxclk domain.
- Commits each complete frame into one of two banks and presents it to the consumer through a random-access read port.
- A consumer acknowledge releases the bank. Frames arriving while both banks are occupied are dropped and counted.

Parameters:
- DEPTH, 4096: bytes per bank; power of two.
- AW, 14: width of the write and read address ports.
- MIN_LEN, 1: minimum committed frame length in bytes; shorter frames are rejected.

Ports:
- rxclk  in  1  sole clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- din  in  8  payload byte.
- wr_addr  in  AW  payload byte address within frame.
- wr_en  in  1  din/wr_addr valid this cycle.
- div_in  in  8  frame div header byte; stable when frm_end is high.
- frm_end  in  1  single-cycle pulse marking end of frame.
- rd_addr  in  AW  consumer read address.
- rd_data  out  8  byte at rd_addr of the presented bank, 1-cycle latency.
- frm_rdy  out  1  presented bank holds a committed frame.
- frm_len  out  AW  length of the presented frame.
- frm_div  out  8  div byte of the presented frame.
- frm_ack  in  1  consumer releases the presented bank.
- drop_cnt  out  16  frames dropped because no bank was free; saturating.
- err_cnt  out  16  frames rejected for being short or truncated; saturating.

Behaviour:

Reset (rst=1 at posedge):
- Writer FSM goes to IDLE; wbank=0, rbank=0, full[1:0]=0.
- frm_rdy=0, frm_len=0, frm_div=0, rd_data=0, drop_cnt=0, err_cnt=0.
- Memory contents are not cleared.
- Reset mid-frame abandons the frame with no counter change.

Writer FSM, states IDLE / FILL / DISCARD:
- IDLE
  - wr_en=1 and full[wbank]=0 -> FILL. The byte is written; len_acc=wr_addr+1; trunc=0.
  - wr_en=1 and full[wbank]=1 -> DISCARD. No write.
  - frm_end without wr_en is ignored.
- FILL
  - Each wr_en with wr_addr<DEPTH writes mem[wbank][wr_addr]=din.
  - len_acc=max(len_acc, wr_addr+1).
  - wr_en with wr_addr>=DEPTH does not write and sets trunc=1.
- FILL, on frm_end (a wr_en in the same cycle is applied first):
  - If trunc=0 and len_acc>=MIN_LEN: commit. len[wbank]=len_acc, div[wbank]=div_in, full[wbank]=1, wbank toggles.
  - Otherwise err_cnt++ and nothing is committed.
  - Next state IDLE in both cases.
- DISCARD
  - Ignores wr_en.
  - On frm_end: drop_cnt++ and go to IDLE.

Reader:
- frm_rdy = full[rbank], registered (updates the cycle after any change).
- frm_len = len[rbank]; frm_div = div[rbank].
- rd_data is registered from mem[rbank][rd_addr mod DEPTH] every cycle, whether or not frm_rdy is set.
- frm_ack while frm_rdy=1: clear full[rbank], toggle rbank. frm_rdy drops the next cycle; it rises again the cycle after if the other bank is full.
- frm_ack while frm_rdy=0 is ignored.

Simultaneous events and invariants:
- A commit and an ack in the same cycle both take effect.
- When wbank==rbank, a commit raises frm_rdy one cycle later.
- The writer never writes a bank whose full flag is set.
- Both counters saturate at 0xFFFF.

Timing:
- wr_en to readable data: 1 cycle after commit.
- rd_addr to rd_data: 1 cycle.

Test Plan:
1. Reset; write addresses 0..63 with din=addr^0x5A, div_in=0x03, pulse frm_end -> frm_rdy=1 two cycles after frm_end; frm_len=64; frm_div=0x03; rd_addr=10 gives rd_data=0x50 one cycle later; frm_ack drops frm_rdy next cycle.
2. Commit frame A (len 16) and frame B (len 32) without ack, then send frame C -> C is not written; drop_cnt=1; ack A -> frm_rdy reasserts with frm_len=32 and B's data.
3. Frame with a byte at wr_addr=DEPTH -> no commit; err_cnt=1; frm_rdy stays 0; the next valid frame commits normally into the same bank.
4. MIN_LEN=8; frame of 4 bytes -> err_cnt=1, no commit; frame of 8 bytes -> frm_len=8.
5. Assert frm_ack in the same cycle as the frm_end of the second frame, with the first frame presented -> first bank released, second committed, frm_rdy low for exactly one cycle, then high with the second frame's len/div.
6. Assert rst mid-FILL after 20 bytes, then send a fresh 5-byte frame -> frm_rdy=1, frm_len=5, err_cnt=0, drop_cnt=0.
